seg7_scan_driver: RTL and testbench

Time-multiplexed driver for the four-digit, active-low, common-anode seven-segment display. It sits directly downstream of the four cascaded BCD digit counters and consumes their digit values Q1 (units) through Q4 (thousands). It snapshots all four digits once per refresh frame, so a displayed frame never mixes old and new counts. It then scans one digit at a time with a short ghost-suppression blanking gap before each digit.

---
 rtl/seg7_pkg.sv | 27 ++
 rtl/seg7_bcd_decode.sv | 21 ++
 rtl/seg7_scan_driver.sv | 111 +++++++++++
 tb/tb_seg7_scan_driver.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared types and constants for the four-digit seven-segment scan driver.
//   NUM_DIGITS  : number of multiplexed digits
//   seg7_t      : segment vector {g,f,e,d,c,b,a}, active-low
//   bcd_t       : one BCD digit
//   SEG_BLANK   : all segments off
//   SEG_DASH    : only segment g lit, shown for non-BCD values
//   SEG_TABLE   : active-low segment patterns for digits 0..9
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [6:0] seg7_t;
    typedef logic [3:0] bcd_t;

    localparam seg7_t SEG_BLANK = 7'h7F;
    localparam seg7_t SEG_DASH  = 7'h3F;

    // Index 0 is the left-most element of the packed array.
    localparam seg7_t [0:9] SEG_TABLE = {
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

endpackage

// File: rtl/seg7_bcd_decode.sv
// -----------------------------------------------------------------------------
// seg7_bcd_decode
// Combinational BCD to active-low seven-segment decoder.
//   bcd : input digit (0..15)
//   seg : segments {g..a}, active-low; values 10..15 show a dash
// -----------------------------------------------------------------------------
module seg7_bcd_decode
    import seg7_pkg::*;
(
    input  bcd_t  bcd,
    output seg7_t seg
);

    always_comb begin
        seg = SEG_DASH;
        if (bcd < 4'd10) begin
            seg = SEG_TABLE[bcd];
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed driver for a four-digit common-anode display. All four
// digits are captured into a shadow register once per frame so a frame never
// mixes old and new counts; each digit slot begins with a short blanking gap
// that suppresses ghosting while anodes switch.
//
// Parameters:
//   REFRESH_DIV  : clk cycles per digit slot (>= 2)
//   BLANK_CYCLES : cycles at slot start with all anodes off (< REFRESH_DIV)
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   Q1..Q4 : units..thousands BCD digits
//   dp_in  : decimal-point request per digit, bit 0 = units, 1 = lit
//   an     : anode enables, active-low, bit 0 = units
//   seg    : segments {g..a}, active-low
//   dp     : decimal point, active-low
// Build option:
//   LEADING_ZERO_BLANK_EN : blank leading zero digits (units never blanked)
// -----------------------------------------------------------------------------
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] Q1,
    input  logic [3:0] Q2,
    input  logic [3:0] Q3,
    input  logic [3:0] Q4,
    input  logic [3:0] dp_in,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] P_LAST  = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYCLES);

    logic [PW-1:0] p;
    logic [1:0]    i;
    logic [15:0]   shadow_q;
    logic [3:0]    shadow_dp;

    logic  slot_end;
    bcd_t  cur_bcd;
    seg7_t dec_seg;
    logic  lz_blank;

    assign slot_end = (p == P_LAST);
    assign cur_bcd  = shadow_q[{i, 2'b00} +: 4];

    seg7_bcd_decode u_decode (
        .bcd (cur_bcd),
        .seg (dec_seg)
    );

    // A digit is a leading zero when it and every higher digit are zero.
    always_comb begin
        lz_blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        case (i)
            2'd3:    lz_blank = (shadow_q[15:12] == 4'd0);
            2'd2:    lz_blank = (shadow_q[15:8]  == 8'd0);
            2'd1:    lz_blank = (shadow_q[15:4]  == 12'd0);
            default: lz_blank = 1'b0;
        endcase
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p         <= '0;
            i         <= 2'd0;
            shadow_q  <= 16'd0;
            shadow_dp <= 4'd0;
            an        <= 4'b1111;
            seg       <= SEG_BLANK;
            dp        <= 1'b1;
        end else begin
            if (slot_end) begin
                p <= '0;
                i <= i + 2'd1;
                // Capture on the last cycle of the frame so the next frame
                // starts with a coherent snapshot.
                if (i == 2'd3) begin
                    shadow_q  <= {Q4, Q3, Q2, Q1};
                    shadow_dp <= dp_in;
                end
            end else begin
                p <= p + 1'b1;
            end

            // Outputs reflect this cycle's (i, p, shadow), one cycle later.
            if (p < P_BLANK) begin
                an  <= 4'b1111;
                seg <= SEG_BLANK;
                dp  <= 1'b1;
            end else begin
                an  <= ~(4'b0001 << i);
                seg <= lz_blank ? SEG_BLANK : dec_seg;
                dp  <= ~shadow_dp[i];
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
// Self-checking bench for seg7_scan_driver with REFRESH_DIV = 8 and
// BLANK_CYCLES = 2. The reference derives every expected output from the
// number of clock edges since reset (slot = n / RD, offset = n % RD) and a
// frame snapshot taken at the frame boundary.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

    localparam int RD    = 8;
    localparam int BL    = 2;
    localparam int FRAME = 4 * RD;

    logic       clk;
    logic       rst_n;
    logic [3:0] Q1, Q2, Q3, Q4;
    logic [3:0] dp_in;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int checks;
    int errors;

    // Reference state: edges since reset and the frame snapshot.
    int          n;
    logic [15:0] snap;
    logic [3:0]  snap_dp;
    logic [11:0] exp_q[$];

    seg7_scan_driver #(
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .Q1    (Q1),
        .Q2    (Q2),
        .Q3    (Q3),
        .Q4    (Q4),
        .dp_in (dp_in),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s n=%0d got=%h exp=%h", tag, n, got, exp);
        end
    endtask

    function automatic logic [6:0] ref_seg(input int v);
        case (v)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    // Expected {an, seg, dp} for the output produced by edge number n.
    function automatic logic [11:0] ref_out(input int cyc, input logic [15:0] sd, input logic [3:0] sdp);
        int pp;
        int ii;
        int d;
        logic [3:0] ea;
        logic [6:0] es;
        logic       ed;
        pp = cyc % RD;
        ii = (cyc / RD) % 4;
        if (pp < BL) return {4'hF, 7'h7F, 1'b1};
        ea     = 4'hF;
        ea[ii] = 1'b0;
        d      = int'((sd >> (4 * ii)) & 16'hF);
        es     = ref_seg(d);
`ifdef LEADING_ZERO_BLANK_EN
        if (ii > 0 && (sd >> (4 * ii)) == 16'd0) es = 7'h7F;
`endif
        ed = ~sdp[ii];
        return {ea, es, ed};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_q(input logic [3:0] q4, input logic [3:0] q3, input logic [3:0] q2,
                         input logic [3:0] q1, input logic [3:0] dpv);
        Q4 = q4; Q3 = q3; Q2 = q2; Q1 = q1; dp_in = dpv;
    endtask

    task automatic step();
        logic [11:0] e;
        exp_q.push_back(ref_out(n, snap, snap_dp));
        if ((n % FRAME) == FRAME - 1) begin
            snap    = {Q4, Q3, Q2, Q1};
            snap_dp = dp_in;
        end
        n++;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_val("an",  16'(an),  16'(e[11:8]));
        check_val("seg", 16'(seg), 16'(e[7:1]));
        check_val("dp",  16'(dp),  16'(e[0]));
    endtask

    task automatic run(input int cycles);
        for (int k = 0; k < cycles; k++) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_an"},  16'(an),  16'hF);
        check_val({tag, "_seg"}, 16'(seg), 16'h7F);
        check_val({tag, "_dp"},  16'(dp),  16'h1);
    endtask

    task automatic model_reset();
        n       = 0;
        snap    = 16'd0;
        snap_dp = 4'd0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        checks = 0;
        errors = 0;
        model_reset();
        rst_n = 1'b0;
        set_q(4'd4, 4'd3, 4'd2, 4'd1, 4'b0000);

        // Reset held: outputs at reset values across clock edges.
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check_reset_outputs("reset_hold");
        end
        rst_n = 1'b1;

        // Scan order: first frame shows zeros, second frame shows 1,2,3,4.
        set_q(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000);
        run(2 * FRAME);

        // Snapshot coherence: change Q1 while digit 2 is scanning.
        for (int k = 0; k < FRAME && ((n / RD) % 4) != 2; k++) step();
        Q1 = 4'd5;
        run(2 * FRAME);

        // Invalid tens digit and dp on hundreds.
        set_q(4'd1, 4'd2, 4'd12, 4'd5, 4'b0100);
        run(2 * FRAME);

        // Leading zeros.
        set_q(4'd0, 4'd0, 4'd7, 4'd0, 4'b0000);
        run(2 * FRAME);

        // All zeros: units digit must stay visible.
        set_q(4'd0, 4'd0, 4'd0, 4'd0, 4'b0001);
        run(2 * FRAME);

        // Reset mid-slot at p = 5, i = 2.
        set_q(4'd9, 4'd8, 4'd6, 4'd3, 4'b1010);
        for (int k = 0; k < FRAME && (n % FRAME) != 2 * RD + 5; k++) step();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_async");
        @(posedge clk);
        #1;
        check_reset_outputs("reset_mid");
        rst_n = 1'b1;
        model_reset();
        run(2 * FRAME);

        // Randomized digit and dp changes.
        for (int k = 0; k < 1200; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 4))
                    0: Q1 = 4'($urandom_range(0, 15));
                    1: Q2 = 4'($urandom_range(0, 15));
                    2: Q3 = 4'($urandom_range(0, 15));
                    3: Q4 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                    default: dp_in = 4'($urandom_range(0, 15));
                endcase
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
